// File: rtl/bar_plot_pkg.sv
// ---------------------------------------------------------------------------
// bar_plot_pkg
// Shared definitions for the bar plotting datapath: screen geometry, bus
// widths, the sweep FSM state encoding and a row-clipping helper.
// No ports (package).
// ---------------------------------------------------------------------------
package bar_plot_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOUR_W     = 3;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;

  // ERASE is only ever entered when the erase feature is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturate a row value to the bottom row of the screen.
  function automatic logic [Y_W-1:0] clip_row(input logic [Y_W-1:0] row,
                                              input logic [Y_W-1:0] maxRow);
    return (row > maxRow) ? maxRow : row;
  endfunction

endpackage

// File: rtl/bar_plot_datapath_pixel_scan_counter.sv
// ---------------------------------------------------------------------------
// pixel_scan_counter
// Two-dimensional column-fast scan counter used for both the erase and the
// draw sweep. cx runs 0..width-1, then wraps and cy advances. last flags the
// final pixel of the rectangle (cx = width-1 and cy = yhi).
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   init            load cx = 0, cy = ylo (wins over enable)
//   enable          advance one pixel
//   ylo             first row of the sweep (used on init)
//   yhi             last row of the sweep (used for last)
//   width           bar width in pixels, 1..16
//   cx, cy          current column offset and row
//   last            current position is the final pixel
// ---------------------------------------------------------------------------
module pixel_scan_counter
  import bar_plot_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  input  logic           enable,
  input  logic [Y_W-1:0] ylo,
  input  logic [Y_W-1:0] yhi,
  input  logic [4:0]     width,
  output logic [3:0]     cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);

  logic [3:0]     cx_q;
  logic [Y_W-1:0] cy_q;
  logic           colLast;

  // End of a row is detected in 5 bits so that a width of 16 compares cleanly.
  always_comb begin
    colLast = ({1'b0, cx_q} == (width - 5'd1));
    last    = colLast && (cy_q == yhi);
  end

  // Counter register: init restarts the rectangle, enable walks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (init) begin
      cx_q <= '0;
      cy_q <= ylo;
    end else if (enable) begin
      if (colLast) begin
        cx_q <= '0;
        cy_q <= cy_q + 7'd1;
      end else begin
        cx_q <= cx_q + 4'd1;
      end
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;

endmodule

// File: rtl/bar_plot_datapath.sv
// ---------------------------------------------------------------------------
// bar_plot_datapath
// Captures top row, bottom row and colour from the switch bus under the load
// FSM strobes, and on a rising edge of writeEn sweeps a filled vertical bar
// one pixel per clock into the 160x120 VGA adapter.
// Optional feature macro: BAR_ERASE_EN -- when defined, the previous bar's
// row span is first swept in black before the new bar is drawn.
// Ports:
//   clk, resetn     clock / asynchronous active-low reset
//   data_in         row value from switches (clipped to SCREEN_H-1)
//   colour_in       RGB colour from switches
//   ld_top          load data_in into the top register
//   ld_bottom       load data_in into the bottom register
//   ld_color        load colour_in into the colour register
//   writeEn         draw request (level, rising edge starts a sweep)
//   x, y, colour    pixel to the VGA adapter
//   plot            pixel valid strobe
//   busy            sweep in progress
//   done            sweep complete
// ---------------------------------------------------------------------------
module bar_plot_datapath
  import bar_plot_pkg::*;
#(
  parameter logic [X_W-1:0] X_POS    = 8'd40,
  parameter int             BAR_W    = 4,
  parameter int             SCREEN_H = SCREEN_H_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [Y_W-1:0]      data_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                ld_top,
  input  logic                ld_bottom,
  input  logic                ld_color,
  input  logic                writeEn,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [Y_W-1:0] MAX_ROW = Y_W'(SCREEN_H - 1);
  localparam logic [4:0]     WIDTH   = 5'(BAR_W);

  state_t              state_q;
  logic [Y_W-1:0]      top_q, bot_q;
  logic [COLOUR_W-1:0] col_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q, busy_q, done_q;
  logic                wePrev_q;

  logic                idleOrDone;
  logic                startEdge;
  logic [Y_W-1:0]      yLo, yHi;
  logic                cntInit, cntEnable, cntLast;
  logic [Y_W-1:0]      cntYlo, cntYhi;
  logic [3:0]          cntCx;
  logic [Y_W-1:0]      cntCy;
  state_t              startState_d;

`ifdef BAR_ERASE_EN
  logic [Y_W-1:0]      oldLo_q, oldHi_q;
  logic                oldValid_q;
`endif

  // Loads and starts are only accepted once the sweep has fully retired;
  // busy_q covers the single DONE cycle in which the last pixel is still
  // on the outputs.
  always_comb begin
    idleOrDone = ((state_q == IDLE) || (state_q == DONE)) && !busy_q;
    startEdge  = idleOrDone && writeEn && !wePrev_q;
    yLo        = (top_q < bot_q) ? top_q : bot_q;
    yHi        = (top_q < bot_q) ? bot_q : top_q;
  end

  // Counter steering. In ERASE the end row comes from the stored old span,
  // while the re-init at the end of ERASE already targets the new bar, so
  // ylo and yhi are selected independently and never loop through last.
  always_comb begin
    cntEnable    = (state_q == DRAW) || (state_q == ERASE);
    cntYlo       = yLo;
    cntYhi       = yHi;
    cntInit      = startEdge;
    startState_d = DRAW;
`ifdef BAR_ERASE_EN
    if (state_q == ERASE) begin
      cntYhi  = oldHi_q;
      cntInit = cntLast;
    end else if (oldValid_q) begin
      cntYlo       = oldLo_q;
      startState_d = ERASE;
    end
`endif
  end

  pixel_scan_counter u_scan (
    .clk    (clk),
    .rst_n  (resetn),
    .init   (cntInit),
    .enable (cntEnable),
    .ylo    (cntYlo),
    .yhi    (cntYhi),
    .width  (WIDTH),
    .cx     (cntCx),
    .cy     (cntCy),
    .last   (cntLast)
  );

  // Sweep FSM with registered pixel outputs. Each DRAW/ERASE clock registers
  // the counter's current position, so the first pixel appears one clock
  // after the start edge and done one clock after the last pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      top_q      <= '0;
      bot_q      <= '0;
      col_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wePrev_q   <= 1'b0;
`ifdef BAR_ERASE_EN
      oldLo_q    <= '0;
      oldHi_q    <= '0;
      oldValid_q <= 1'b0;
`endif
    end else begin
      wePrev_q <= writeEn;
      if (idleOrDone) begin
        if (ld_top)    top_q <= clip_row(data_in, MAX_ROW);
        if (ld_bottom) bot_q <= clip_row(data_in, MAX_ROW);
        if (ld_color)  col_q <= colour_in;
      end
      case (state_q)
        IDLE: begin
          plot_q <= 1'b0;
          if (startEdge) begin
            state_q <= startState_d;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
`ifdef BAR_ERASE_EN
        ERASE: begin
          plot_q   <= 1'b1;
          x_q      <= X_POS + {4'd0, cntCx};
          y_q      <= cntCy;
          colour_q <= '0;
          if (cntLast) state_q <= DRAW;
        end
`endif
        DRAW: begin
          plot_q   <= 1'b1;
          x_q      <= X_POS + {4'd0, cntCx};
          y_q      <= cntCy;
          colour_q <= col_q;
          if (cntLast) begin
            state_q <= DONE;
`ifdef BAR_ERASE_EN
            oldLo_q    <= yLo;
            oldHi_q    <= yHi;
            oldValid_q <= 1'b1;
`endif
          end
        end
        DONE: begin
          plot_q <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (startEdge) begin
            state_q <= startState_d;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else if (!writeEn) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          plot_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
